// File: rtl/regfile_responder_pkg.sv
// Shared types and defaults for the register-file responder.
// Opcode and FSM encodings live here so the ALU and the top agree.
package regfile_responder_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ1 = 3'd1,
        OP_READ2 = 3'd2,
        OP_WRITE = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_SHL   = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_alu.sv
// Writeback result selection for WRITE/ADD/SUB/SHL.
// Purely combinational; operands arrive already registered.
module regfile_alu
    import regfile_responder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_r1,
    input  logic [WIDTH-1:0] i_r2,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_result
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    always_comb begin
        o_result = i_wdata;
        unique case (i_op)
            OP_ADD:  o_result = i_r1 + i_r2;
            OP_SUB:  o_result = i_r1 - i_r2;
            // full-width compare so any large shift amount yields zero
            OP_SHL:  o_result = (i_r2 >= SH_LIM) ? '0
                              : (i_r1 << i_r2[SW-1:0]);
            default: o_result = i_wdata;
        endcase
    end

endmodule

// File: rtl/regfile_responder.sv
// Register-file responder: accepts one command, waits a fixed
// latency, then pulses done with read data / commits the writeback.
module regfile_responder
    import regfile_responder_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             done,
    output logic             err
);

    localparam int MAXL = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
    localparam int CW   = $clog2(MAXL + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    op_e              r_op;
    logic [AW-1:0]    r_wa;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic             r_ready;
    logic             r_done;
    logic             r_err;

    op_e              w_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;

    assign w_op     = op_e'(cmd_op);
    assign w_accept = cmd_valid && r_ready;

    regfile_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_r1     (r_op1),
        .i_r2     (r_op2),
        .i_wdata  (r_wdata),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_wa    <= '0;
            r_wdata <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // operands snapshot here gives pre-write self-reference
                        r_op    <= w_op;
                        r_wa    <= wr_addr;
                        r_wdata <= wr_data;
                        r_op1   <= r_mem[rd_addr1];
                        r_op2   <= r_mem[rd_addr2];
                        r_ready <= 1'b0;
                        unique case (w_op)
                            OP_READ1, OP_READ2: begin
                                r_state <= S_RD_WAIT;
                                r_cnt   <= RD_LOAD;
                            end
                            OP_WRITE, OP_ADD, OP_SUB, OP_SHL: begin
                                r_state <= S_WR_WAIT;
                                r_cnt   <= WR_LOAD;
                            end
                            default: begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_err   <= (w_op == OP_RSVD);
                            end
                        endcase
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_rd1   <= r_op1;
                        if (r_op == OP_READ2) r_rd2 <= r_op2;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_mem[r_wa]  <= w_result;
                        if (r_op != OP_WRITE) begin
                            r_rd1 <= r_op1;
                            r_rd2 <= r_op2;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rd_data1  = r_rd1;
    assign rd_data2  = r_rd2;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: doc/regfile_responder.md
Name: regfile_responder

Overview:
- Responder end of the register-file command interface: accepts one opcode plus addresses and data per transaction and returns read data plus a one-cycle done pulse.
- Executes reads, plain writes, and register-to-register ADD/SUB/SHL writebacks.
- Writes use a fixed multi-cycle commit latency.
- Holds 32 x 16-bit registers. Sits below the command controller that issues opcodes and waits for done.

Parameters:
- DEPTH, 32, number of registers; address width is log2(DEPTH) = 5.
- WIDTH, 16, register and data width.
- READ_LAT, 1, cycles from acceptance to read data valid / done; minimum 1.
- WRITE_LAT, 16, cycles from acceptance to write commit / done; minimum 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  responder idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  opcode: 0 NOP, 1 READ1, 2 READ2, 3 WRITE, 4 ADD, 5 SUB, 6 SHL, 7 reserved.
- rd_addr1  in  5  first read address.
- rd_addr2  in  5  second read address.
- wr_addr  in  5  write address.
- wr_data  in  16  write data; used by op 3 only.
- rd_data1  out  16  read data for rd_addr1.
- rd_data2  out  16  read data for rd_addr2.
- done  out  1  one-cycle completion pulse.
- err  out  1  asserted together with done when the op was 7.

Behaviour:
- Reset values:
  - all registers 0;
  - rd_data1 = rd_data2 = 0;
  - done = 0, err = 0;
  - cmd_ready = 1;
  - FSM in IDLE.
- Reset mid-operation: aborts the operation, commits nothing, emits no done.
- Command capture: on acceptance, cmd_op, all addresses and wr_data are registered. Inputs are ignored while busy; cmd_ready = 0 outside IDLE.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
  - IDLE -> RD_WAIT for ops 1 and 2.
  - IDLE -> WR_WAIT for ops 3 to 6.
  - IDLE -> DONE for ops 0 and 7.
- Latency counter: loaded with LAT-1 on entry to a wait state; the FSM moves to DONE when it reaches 0.
- DONE: done = 1 for exactly one cycle, then IDLE with cmd_ready = 1.
- Back-to-back: a new command is accepted at the earliest in the cycle after done.
- Timing:
  - NOP / reserved: done one cycle after acceptance.
  - READ: done READ_LAT + 1 cycles after acceptance.
  - WRITE-class: done WRITE_LAT + 1 cycles after acceptance.
- READ1: rd_data1 = reg[rd_addr1] sampled at acceptance. rd_data2 holds its previous value.
- READ2: both ports sampled at acceptance. Both outputs update in the DONE cycle and hold until the next read-class op.
- WRITE-class: operands are read at acceptance. The result is computed into a WIDTH-bit temp and written to reg[wr_addr] in the last WR_WAIT cycle, so it is visible to any command accepted after done.
  - WRITE: result = wr_data.
  - ADD: result = r1 + r2 mod 2^16, carry dropped.
  - SUB: result = r1 - r2 mod 2^16, two's complement wrap.
  - SHL: result = r1 << r2; result = 0 if r2 >= 16 (full 16-bit compare).
  - For ADD/SUB/SHL, rd_data1 and rd_data2 also present the operand values in the DONE cycle.
- Self-reference: wr_addr equal to rd_addr1 and/or rd_addr2 is legal; operands are the pre-write values.
- Address 0 is an ordinary writable register, with no hardwired zero.
- Op 7: no register change, outputs unchanged, err = 1 with done.

Decomposition:
- Shared package: opcode constants (OP_NOP through OP_RSVD), FSM state encoding, and the WIDTH/DEPTH defaults.
- One natural sub-module, regfile_alu: combinational WRITE/ADD/SUB/SHL result selection from op, r1, r2 and wr_data.
- Register array, FSM and latency counter stay in regfile_responder.

Test Plan:
- Reset, then READ2 of addresses 3 and 7 -> done at cycle 2, rd_data1 = rd_data2 = 0, err = 0.
- WRITE addr 5 = 0x1234 -> cmd_ready low for 17 cycles, done at cycle 17; then READ1 addr 5 -> 0x1234.
- Preload r1 = 0xFFFF, r2 = 0x0002; ADD into r1 -> r1 = 0x0001 (self-reference uses old value). Then SUB r2 - r1 into addr 9 -> 0x0001.
- Preload r4 = 0x0003; SHL r4 by 4 -> 0x0030; SHL r4 by 16 -> 0x0000; SHL by 15 -> 0x8000.
- WRITE addr 6 = 0xBEEF with reset pulsed at cycle 8 -> no done, READ1 addr 6 -> 0x0000. Also check that a cmd_valid held during busy is not accepted twice.
- Op 7 -> done + err at cycle 1, all registers unchanged. NOP -> done, err = 0.
